// File: rtl/dft_pkg.sv
// Shared DFT constants and the dump-sink FSM state type.
package dft_pkg;

    localparam int DFT_WORD_W         = 32;
    localparam int DFT_CHAIN_LEN      = 64;
    localparam int DFT_WORDS_PER_DUMP = DFT_CHAIN_LEN / DFT_WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ACK,
        WAIT_LOW
    } sink_state_t;

endpackage

// File: rtl/dft_sink_fifo.sv
// Registered FIFO of {last, data} entries with an in-place "mark tail as last" port.
// The parent guarantees push_i is only raised when not full or when popping in the same cycle.
module dft_sink_fifo #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WORD_W-1:0]        wdata_i,
    input  logic                     wlast_i,
    input  logic                     pop_i,
    input  logic                     mark_last_i,
    output logic [WORD_W-1:0]        rdata_o,
    output logic                     rlast_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [WORD_W:0] mem_q [DEPTH];
    logic [AW-1:0]   tail_idx;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign level_o  = wr_ptr_q - rd_ptr_q;
    assign tail_idx = wr_ptr_q[AW-1:0] - AW'(1);

    assign wr_ptr_d = push_i ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop_i  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]][WORD_W-1:0];
    assign rlast_o = mem_q[rd_ptr_q[AW-1:0]][WORD_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (mark_last_i && !empty_o) begin
            mem_q[tail_idx][WORD_W] <= 1'b1;
        end
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {wlast_i, wdata_i};
        end
    end

endmodule

// File: rtl/dft_dump_sink.sv
// Buffers DFT scan-dump words for the host and closes the commit handshake
// only once the whole dump has been drained.
module dft_dump_sink
    import dft_pkg::*;
#(
    parameter int WORD_W         = DFT_WORD_W,
    parameter int WORDS_PER_DUMP = DFT_WORDS_PER_DUMP,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] dft_out,
    input  logic              dft_out_strobe,
    input  logic              dft_op_commit,
    output logic              dft_commit_ack,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_last,
    output logic              overflow,
    output logic              short_dump,
    input  logic              clr_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORDS_PER_DUMP + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORDS_PER_DUMP);

    sink_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_base;
    logic              overflow_q, overflow_d;
    logic              short_q, short_d;
    logic              ack_c;

    logic              fifo_full, fifo_empty;
    logic [AW:0]       level, level_next;
    logic [WORD_W-1:0] head_data;
    logic              head_last;
    logic              push, pop, drop;
    logic              cnt_inc, push_last, commit_fire, is_short, mark_last, drain_done;

    assign pop        = !fifo_empty && rd_ready;
    assign push       = dft_out_strobe && (!fifo_full || pop);
    assign drop       = dft_out_strobe && fifo_full && !pop;
    assign level_next = level + (AW+1)'(push) - (AW+1)'(pop);
    assign drain_done = (level_next == '0);

    // The push of this cycle is counted before the short-dump check, so a
    // commit arriving with the final word is not reported as short.
    always_comb begin
        cnt_base    = (state_q == ACK) ? '0 : cnt_q;
        cnt_inc     = push && (cnt_base != CNT_FULL);
        cnt_d       = cnt_inc ? cnt_base + CW'(1) : cnt_base;
        push_last   = cnt_inc && (cnt_d == CNT_FULL);
        commit_fire = (state_q == IDLE) && dft_op_commit;
        is_short    = commit_fire && (cnt_d != CNT_FULL);
        mark_last   = is_short && !push;
    end

    always_comb begin
        state_d = state_q;
        ack_c   = 1'b0;
        unique case (state_q)
            IDLE:     if (commit_fire)    state_d = DRAIN;
            DRAIN:    if (drain_done)     state_d = ACK;
            ACK: begin
                ack_c   = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: if (!dft_op_commit) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Sticky flags: a set event in the same cycle beats clr_flags.
    always_comb begin
        overflow_d = drop     ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
        short_d    = is_short ? 1'b1 : (clr_flags ? 1'b0 : short_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
        end
    end

    dft_sink_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .wdata_i     (dft_out),
        .wlast_i     (push_last || is_short),
        .pop_i       (pop),
        .mark_last_i (mark_last),
        .rdata_o     (head_data),
        .rlast_o     (head_last),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    // Head is gated so every output reads 0 while reset holds the FIFO empty.
    assign rd_valid       = !fifo_empty;
    assign rd_data        = rd_valid ? head_data : '0;
    assign rd_last        = rd_valid && head_last;
    assign dft_commit_ack = ack_c;
    assign overflow       = overflow_q;
    assign short_dump     = short_q;

endmodule

// File: tb/tb_dft_dump_sink.sv
// Directed bench for dft_dump_sink: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_dft_dump_sink;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int WPD   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  dft_out = '0;
    logic          dft_out_strobe = 1'b0;
    logic          dft_op_commit = 1'b0;
    logic          dft_commit_ack;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic          overflow;
    logic          short_dump;
    logic          clr_flags = 1'b0;

    int compares = 0;
    int errors   = 0;
    int ackCount = 0;

    logic [W:0] dutPops[$];
    logic [W:0] expPops[$];

    always #5 clk = ~clk;

    dft_dump_sink #(
        .WORD_W         (W),
        .WORDS_PER_DUMP (WPD),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dft_out        (dft_out),
        .dft_out_strobe (dft_out_strobe),
        .dft_op_commit  (dft_op_commit),
        .dft_commit_ack (dft_commit_ack),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .overflow       (overflow),
        .short_dump     (short_dump),
        .clr_flags      (clr_flags)
    );

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compares++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a queue of {last,data} words plus the handshake phase.
    localparam int P_IDLE = 0, P_DRAIN = 1, P_ACK = 2, P_WAITLOW = 3;
    logic [W:0] mq[$];
    logic [W:0] mEntry;
    int  mCnt   = 0;
    int  mPhase = P_IDLE;
    bit  mOvf   = 0;
    bit  mShort = 0;
    bit  mPop, mPush, mFire, mEvOvf, mEvShort;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mCnt   = 0;
            mPhase = P_IDLE;
            mOvf   = 0;
            mShort = 0;
        end else begin
            mPop  = (mq.size() > 0) && rd_ready;
            mPush = dft_out_strobe && ((mq.size() < DEPTH) || mPop);
            mFire = (mPhase == P_IDLE) && dft_op_commit;
            if (mPhase == P_ACK) mCnt = 0;
            if (mPop) void'(mq.pop_front());
            if (mPush) begin
                mEntry = {1'b0, dft_out};
                if (mCnt < WPD) begin
                    mCnt++;
                    if (mCnt == WPD) mEntry[W] = 1'b1;
                end
                mq.push_back(mEntry);
            end
            mEvOvf   = dft_out_strobe && !mPush;
            mEvShort = mFire && (mCnt != WPD);
            if (mEvShort && mq.size() > 0) begin
                mEntry = mq[mq.size()-1];
                mEntry[W] = 1'b1;
                mq[mq.size()-1] = mEntry;
            end
            mOvf   = mEvOvf   ? 1'b1 : (clr_flags ? 1'b0 : mOvf);
            mShort = mEvShort ? 1'b1 : (clr_flags ? 1'b0 : mShort);
            case (mPhase)
                P_IDLE:    if (mFire) mPhase = P_DRAIN;
                P_DRAIN:   if (mq.size() == 0) mPhase = P_ACK;
                P_ACK:     mPhase = P_WAITLOW;
                default:   if (!dft_op_commit) mPhase = P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        checkOutput("rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            checkOutput("rd_data", 64'(rd_data), 64'(mq[0][W-1:0]));
            checkOutput("rd_last", 64'(rd_last), 64'(mq[0][W]));
        end
        checkOutput("ack", 64'(dft_commit_ack), 64'(mPhase == P_ACK));
        checkOutput("overflow", 64'(overflow), 64'(mOvf));
        checkOutput("short_dump", 64'(short_dump), 64'(mShort));
    end

    always @(negedge clk) begin
        if (reset && rd_valid && rd_ready) dutPops.push_back({rd_last, rd_data});
        if (dft_commit_ack) ackCount++;
    end

    task automatic applyStimulus(input logic stb, input logic [W-1:0] d, input logic cm,
                                 input logic rdy, input logic clr);
        dft_out_strobe = stb;
        dft_out        = d;
        dft_op_commit  = cm;
        rd_ready       = rdy;
        clr_flags      = clr;
        @(posedge clk);
        #1;
        dft_out_strobe = 1'b0;
        clr_flags      = 1'b0;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitAck(input string nm, input int budget);
        int start;
        start = ackCount;
        for (int i = 0; i < budget; i++) begin
            if (ackCount > start) break;
            hold(1);
        end
        checkOutput(nm, 64'(ackCount - start), 64'd1);
    endtask

    task automatic expectPop(input logic last, input logic [W-1:0] d);
        expPops.push_back({last, d});
    endtask

    task automatic checkPops(input string nm);
        checkOutput({nm, "_count"}, 64'(dutPops.size()), 64'(expPops.size()));
        for (int i = 0; i < expPops.size() && i < dutPops.size(); i++)
            checkOutput($sformatf("%s_%0d", nm, i), 64'(dutPops[i]), 64'(expPops[i]));
        dutPops.delete();
        expPops.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ackBase;

        // Reset state
        hold(2);
        checkOutput("reset_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_ack", 64'(dft_commit_ack), 64'd0);
        reset = 1'b1;
        hold(2);

        // Normal dump with host always ready
        $display("[TB] normal dump");
        applyStimulus(1, 32'hDEADBEEF, 0, 1, 0);
        applyStimulus(1, 32'h12345678, 0, 1, 0);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("normal_ack", 20);
        ackBase = ackCount;
        hold(5);
        checkOutput("normal_no_double_ack", 64'(ackCount - ackBase), 64'd0);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        expectPop(0, 32'hDEADBEEF);
        expectPop(1, 32'h12345678);
        checkPops("normal_pops");
        checkOutput("normal_short", 64'(short_dump), 64'd0);

        // Back-pressure: host stalls for 10 cycles with commit raised
        $display("[TB] back-pressure");
        ackBase = ackCount;
        applyStimulus(1, 32'hCAFE0001, 0, 0, 0);
        applyStimulus(1, 32'hCAFE0002, 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        hold(10);
        checkOutput("bp_no_early_ack", 64'(ackCount - ackBase), 64'd0);
        checkOutput("bp_stall_data", 64'(rd_data), 64'hCAFE0001);
        checkOutput("bp_stall_last", 64'(rd_last), 64'd0);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("bp_ack", 20);
        hold(3);
        checkOutput("bp_single_ack", 64'(ackCount - ackBase), 64'd1);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        expectPop(0, 32'hCAFE0001);
        expectPop(1, 32'hCAFE0002);
        checkPops("bp_pops");

        // Overflow: five strobes into a depth-4 FIFO with no reader
        $display("[TB] overflow");
        for (int i = 1; i <= 5; i++) applyStimulus(1, W'(i), 0, 0, 0);
        checkOutput("ovf_set", 64'(overflow), 64'd1);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("ovf_ack", 20);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        expectPop(0, 32'd1);
        expectPop(1, 32'd2);
        expectPop(0, 32'd3);
        expectPop(0, 32'd4);
        checkPops("ovf_pops");
        checkOutput("ovf_no_short", 64'(short_dump), 64'd0);
        applyStimulus(0, '0, 0, 1, 1);
        checkOutput("ovf_cleared", 64'(overflow), 64'd0);

        // Short dump: one word then commit
        $display("[TB] short dump");
        applyStimulus(1, 32'hA5A5A5A5, 0, 0, 0);
        checkOutput("short_head_last_before", 64'(rd_last), 64'd0);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("short_set", 64'(short_dump), 64'd1);
        checkOutput("short_head_last", 64'(rd_last), 64'd1);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("short_ack", 20);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        expectPop(1, 32'hA5A5A5A5);
        checkPops("short_pops");
        applyStimulus(0, '0, 0, 1, 1);
        checkOutput("short_cleared", 64'(short_dump), 64'd0);

        // Strobe and commit in the same cycle after one prior word
        $display("[TB] simultaneous strobe and commit");
        applyStimulus(1, 32'h00000011, 0, 0, 0);
        applyStimulus(1, 32'h00000022, 1, 0, 0);
        checkOutput("sim_no_short", 64'(short_dump), 64'd0);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("sim_ack", 20);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        expectPop(0, 32'h00000011);
        expectPop(1, 32'h00000022);
        checkPops("sim_pops");

        // Push and pop together while full: nothing may be dropped
        $display("[TB] push/pop while full");
        for (int i = 1; i <= 4; i++) applyStimulus(1, 32'h30 + W'(i), 0, 0, 0);
        for (int i = 5; i <= 7; i++) applyStimulus(1, 32'h30 + W'(i), 0, 1, 0);
        checkOutput("full_pp_no_ovf", 64'(overflow), 64'd0);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("full_pp_head", 64'(rd_data), 64'h34);
        hold(1);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("full_pp_ack", 20);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        for (int i = 1; i <= 7; i++) expectPop(i == 2, 32'h30 + W'(i));
        checkPops("full_pp_pops");
        checkOutput("full_pp_no_short", 64'(short_dump), 64'd0);

        // Reset while a word is buffered and the handshake is draining
        $display("[TB] reset mid-dump");
        ackBase = ackCount;
        applyStimulus(1, 32'h00000077, 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        hold(1);
        reset = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_data", 64'(rd_data), 64'd0);
        checkOutput("rst_last", 64'(rd_last), 64'd0);
        checkOutput("rst_ack", 64'(dft_commit_ack), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        checkOutput("rst_short", 64'(short_dump), 64'd0);
        dft_op_commit = 1'b0;
        hold(2);
        reset = 1'b1;
        hold(3);
        checkOutput("rst_after_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_no_ack", 64'(ackCount - ackBase), 64'd0);
        applyStimulus(1, 32'hAAAA0001, 0, 1, 0);
        applyStimulus(1, 32'hAAAA0002, 0, 1, 0);
        applyStimulus(0, '0, 1, 1, 0);
        waitAck("rst_next_ack", 20);
        applyStimulus(0, '0, 0, 1, 0);
        hold(1);
        expectPop(0, 32'hAAAA0001);
        expectPop(1, 32'hAAAA0002);
        checkPops("rst_next_pops");

        hold(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule

// File: doc/dft_dump_sink.md
Name: dft_dump_sink

Overview:
Downstream consumer of the scan-dump side of the DFT top level. It captures each 32-bit `dft_out` word qualified by `dft_out_strobe` into a small FIFO and presents the words to the host as a valid/ready stream, tagging the last word of each dump. It closes the DFT commit handshake: `dft_commit_ack` is returned only after every word of the dump has been drained by the host.

Parameters:
- WORD_W, 32, width of a scan dump word; must match `dft_out`.
- WORDS_PER_DUMP, 2, words expected per dump (64-bit chain / 32).
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥ WORDS_PER_DUMP.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- dft_out  in  WORD_W  scan dump word from the DFT datapath.
- dft_out_strobe  in  1  one-cycle qualifier; `dft_out` is valid this cycle.
- dft_op_commit  in  1  DFT op finished; held high until acknowledged.
- dft_commit_ack  out  1  one-cycle pulse closing the commit handshake.
- rd_valid  out  1  FIFO head is valid.
- rd_ready  in  1  host accepts the head word.
- rd_data  out  WORD_W  FIFO head word.
- rd_last  out  1  head word is the final word of its dump.
- overflow  out  1  sticky: a strobe arrived while the FIFO was full.
- short_dump  out  1  sticky: commit arrived with a word count ≠ WORDS_PER_DUMP.
- clr_flags  in  1  synchronous clear of `overflow` and `short_dump`.

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0.
  - FIFO is empty, pointers are 0, word counter is 0, FSM is IDLE.
  - Reset mid-dump discards buffered words and emits no ack.
- Push and pop:
  - Push when `dft_out_strobe`=1 and (not full, or a pop happens in the same cycle).
  - Pop when `rd_valid` and `rd_ready` are both 1.
  - Push and pop in the same cycle, full or not, leave occupancy unchanged.
  - Strobe while full with no pop: the word is dropped and `overflow` is set. The dropped word is not counted.
- Latency:
  - A pushed word appears on `rd_valid`/`rd_data` in the cycle after the strobe (registered FIFO, no bypass).
  - `rd_data` and `rd_last` are stable while `rd_valid`=1 and `rd_ready`=0.
- Word counter:
  - Counts accepted pushes within the current dump.
  - Saturates at WORDS_PER_DUMP.
  - The push that makes count == WORDS_PER_DUMP stores its entry with last=1.
  - The counter clears when the FSM leaves ACK.
- FSM states:
  - IDLE: on `dft_op_commit`=1, go to DRAIN. If count ≠ WORDS_PER_DUMP, set `short_dump` and force last=1 on the most recently stored entry; if no word is stored, no entry is modified.
  - DRAIN: wait until the FIFO is empty (including the cycle where the last pop empties it), then go to ACK. Strobes arriving in DRAIN are still accepted and counted.
  - ACK: `dft_commit_ack`=1 for exactly one cycle, then go to WAIT_LOW.
  - WAIT_LOW: stay until `dft_op_commit`=0, then go to IDLE. This prevents a double ack on a held commit.
- Commit and strobe in the same cycle: the word is pushed first and counted before the short-dump check.
- `clr_flags` in the same cycle as a set event: the set wins.
- Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty is decided by comparing the MSB and the remaining bits; pointers wrap naturally.

Decomposition:
- Shared package `dft_pkg`:
  - DFT_WORD_W=32.
  - DFT_CHAIN_LEN=64.
  - DFT_WORDS_PER_DUMP=DFT_CHAIN_LEN/DFT_WORD_W.
  - FSM state encoding `sink_state_t`: IDLE, DRAIN, ACK, WAIT_LOW.
- Sub-module `dft_sink_fifo`:
  - Synchronous FIFO of WORD_W+1 bits (data + last).
  - Provides push, pop, full, empty, and a mark-last-of-tail port.
  - Reuses the same clk and async active-low reset.

Test Plan:
- Normal dump: strobes with 0xDEADBEEF then 0x12345678, rd_ready=1, commit raised.
  - rd_data order: 0xDEADBEEF, then 0x12345678; rd_last=0, then 1.
  - dft_commit_ack pulses once, one cycle after the FIFO empties; no second ack while commit stays high.
- Back-pressure: rd_ready=0 while 2 words arrive, commit raised, rd_ready released 10 cycles later.
  - No ack before the second pop; ack occurs exactly once afterwards.
  - rd_data holds stable during the stall.
- Overflow (FIFO_DEPTH=4, rd_ready=0): 5 strobes with values 1..5.
  - overflow=1 after the 5th strobe; the FIFO drains values 1..4; word 5 is lost.
  - clr_flags clears overflow.
- Short dump: 1 strobe (0xA5A5A5A5), then commit.
  - short_dump=1; the word is drained with rd_last=1; ack is returned.
- Simultaneous events:
  - Strobe and commit in the same cycle after 1 prior word: no short_dump, second word has last=1.
  - Push and pop while full: occupancy stays at 4.
- Reset mid-dump: assert reset while 1 word is buffered and the FSM is in DRAIN.
  - All outputs read 0 immediately (asynchronously).
  - After release: FSM is IDLE, FIFO is empty, no ack emitted.
